serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_fa_cell.sv | 16 +
 rtl/serial_adder.sv | 133 +++++++++++++
 tb/tb_serial_adder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding, default width
// and the bit-counter width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bits needed to count 0 .. width-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder used as the serial adder's datapath cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of one bit position.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit per clock.
// Handshake: operands and carry-in are captured when start is seen in IDLE;
// start in RUN or DONE is dropped, never queued. busy is high in RUN and
// DONE; done is a single-cycle pulse marking sum/co (and ovf) valid. The
// result registers hold until the next operation completes.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow
// output ovf (carry into MSB xor carry out).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output state_e           dbg_state
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  // Only the upper WIDTH-1 sum bits need storing: the final bit comes
  // straight from the cell on the last RUN edge.
  logic [WIDTH-2:0] sum_sr_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             co_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] sum_sr_d;

  fa_cell u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts the word is aligned.
  always_comb begin
    sum_sr_d = {fa_s, sum_sr_q};
  end

  // Control FSM and datapath registers with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      co_q     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= ci;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          sum_sr_q <= sum_sr_d[WIDTH-1:1];
          carry_q  <= fa_c;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            sum_q   <= sum_sr_d;
            co_q    <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q is the carry into the MSB during the last RUN cycle.
            ovf_q   <= carry_q ^ fa_c;
`endif
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign co        = co_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for timing, hold,
// ignore-start and reset-abort behaviour, and a 4-bit instance swept
// exhaustively. Expected results are queued when an operation is launched
// and popped when done is seen.
module tb_serial_adder;
  import serial_adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 8-bit DUT ----------------
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ci8 = 1'b0;
  logic       busy8, done8, co8;
  logic [7:0] sum8;
  state_e     st8;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8;
`endif

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .ci(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .co(co8),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf8),
`endif
    .dbg_state(st8)
  );

  // ---------------- 4-bit DUT ----------------
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ci4 = 1'b0;
  logic       busy4, done4, co4;
  logic [3:0] sum4;
  state_e     st4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf4;
`endif

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .ci(ci4),
    .busy(busy4), .done(done4), .sum(sum4), .co(co4),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf4),
`endif
    .dbg_state(st4)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];   // {co, sum} for the 8-bit DUT
  logic       exp_ovf_q[$];
  logic [4:0] exp4_q[$];  // {co, sum} for the 4-bit DUT
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Launch an 8-bit op: drive away from the edge, let edge 0 accept it.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] full;
    full = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    exp_q.push_back(full);
    exp_ovf_q.push_back((a[7] == b[7]) && (full[7] != a[7]));
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; ci8 = ci;
    @(posedge clk);  // edge 0
    #1;
    start8 = 1'b0;
    check("busy_after_accept", busy8, 1'b1);
  endtask

  // Wait for done after start_op8. inject_at > 0 pulses a start with FF/FF
  // during that RUN edge; hold_sum is the prior result expected to stay put.
  task automatic wait_done8(input string tag, input int inject_at, input logic [8:0] hold_val);
    int k;
    int busy_cnt;
    logic [8:0] e;
    logic eo;
    busy_cnt = 1;
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      if (i == inject_at) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
      end
      @(posedge clk);
      #1;
      start8 = 1'b0;
      if (busy8) busy_cnt++;
      if (i == 4) check({tag, "_hold_during_run"}, {co8, sum8}, hold_val);
      if (done8) begin
        k = i;
        break;
      end
    end
    check({tag, "_done_latency"}, k, 8);
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      eo = exp_ovf_q.pop_front();
      check({tag, "_sum"}, sum8, e[7:0]);
      check({tag, "_co"}, co8, e[8]);
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, "_ovf"}, ovf8, eo);
`else
      if (eo === 1'bx) check({tag, "_ovf_model"}, 0, 1);
`endif
    end
    @(posedge clk);
    #1;
    if (busy8) busy_cnt++;
    check({tag, "_done_single_pulse"}, done8, 1'b0);
    check({tag, "_busy_cycles"}, busy_cnt, 9);
    check({tag, "_back_in_idle"}, busy8, 1'b0);
  endtask

  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [4:0] e;
    bit seen;
    exp4_q.push_back({1'b0, a} + {1'b0, b} + {4'd0, ci});
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; ci4 = ci;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done4) begin
        seen = 1'b1;
        break;
      end
    end
    e = exp4_q.pop_front();
    if (!seen) check("w4_timeout", 0, 1);
    else if ({co4, sum4} !== e) check($sformatf("w4_%h_%h_%b", a, b, ci), {co4, sum4}, e);
    else checks++;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [8:0] prev;
    int dones;
    #23;
    // Reset state, sampled while rst_n is still low.
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_sum", sum8, 8'h00);
    check("rst_co", co8, 1'b0);
    check("rst_state", st8, ST_IDLE);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", ovf8, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    start_op8(8'h05, 8'h03, 1'b0); wait_done8("t05_03", 0, 9'h000);
    start_op8(8'hFF, 8'h01, 1'b0); wait_done8("tFF_01", 0, 9'h008);
    start_op8(8'h7F, 8'h01, 1'b0); wait_done8("t7F_01", 0, 9'h100);
    start_op8(8'hFF, 8'hFF, 1'b1); wait_done8("tFF_FF", 0, 9'h080);

    // start during RUN must be dropped.
    start_op8(8'h10, 8'h20, 1'b0); wait_done8("ignore", 3, 9'h1FF);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("ignored_start_not_queued", busy8, 1'b0);
    end

    // Reset mid-RUN: outputs clear at once and no done follows.
    start_op8(8'h3C, 8'h11, 1'b0);
    exp_q.delete();
    exp_ovf_q.delete();
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    check("abort_sum", sum8, 8'h00);
    check("abort_co", co8, 1'b0);
    check("abort_state", st8, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done8) dones++;
    end
    check("abort_no_done", dones, 0);
    start_op8(8'h01, 8'h01, 1'b0); wait_done8("after_abort", 0, 9'h000);

    // start held high: operations keep launching from IDLE.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h21; b8 = 8'h42; ci8 = 1'b1;
    dones = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      if (done8) begin
        dones++;
        check("held_start_sum", {co8, sum8}, 9'h064);
      end
    end
    start8 = 1'b0;
    prev = {co8, sum8};
    check("held_start_multiple", (dones >= 2), 1'b1);
    repeat (12) @(posedge clk);
    #1;
    check("held_start_result_hold", {co8, sum8}, prev);

    // Exhaustive 4-bit sweep.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          run_op4(4'(x), 4'(y), 1'(c));

    check("scoreboard_empty", exp_q.size() + exp4_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
